// File: rtl/bounce_gen_pkg.sv
// Shared types, constants and LFSR step function for the bounce_gen switch emulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bounce_gen_pkg;

  // Transition sequencer states
  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  // Galois feedback taps (right-shifting form)
  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One step of the 16-bit Galois LFSR: shift right, fold taps in when the bit shifted out is 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_POLY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running-on-demand 16-bit Galois LFSR that supplies random gap extensions.
// Latency: value_o updates one clock after step_i.
// Backpressure: none; holds its value whenever step_i is low.
module bounce_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  // An all-zero state would lock the register up, so a zero seed becomes 1
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;

  // Advance once per step request, hold otherwise; reset reloads the seed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED_SAFE;
    end else if (step_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign value_o = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: drives sw_o to a target through 2*BOUNCES glitch toggles, then settles and pulses done.
// Latency: sw_o follows level_i on the accepting edge; done_tick_o at E0 + sum(gaps) + SETTLE. Config macro: BOUNCE_GEN_RANDOM_EN.
// Backpressure: req_i is only accepted while idle (including the done cycle); requests while busy are dropped.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned BOUNCES  = 4,
  parameter int unsigned MIN_GAP  = 10,
  parameter int unsigned GAP_BITS = 6,
  parameter int unsigned SETTLE   = 1000,
  parameter logic [15:0] SEED     = LFSR_DEFAULT_SEED
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic level_i,
  output logic sw_o,
  output logic busy_o,
  output logic done_tick_o
);

  // Toggle counter counts completed toggles 0..2*BOUNCES-1; keep at least one bit for the clean-edge build
  localparam int unsigned TOG_W = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  localparam logic [TOG_W-1:0] LAST_TOG    = (BOUNCES > 0) ? TOG_W'(2 * BOUNCES - 1) : '0;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(1);

  state_t            state_q, state_d;
  logic              sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       gap_q, gap_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  logic [SET_W-1:0]  set_q, set_d;

  logic              lfsr_step;
  logic [GAP_BITS-1:0] rnd;
  logic [31:0]       gap_new;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] lfsr_val;
  logic        unused_lfsr;

  bounce_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (lfsr_step),
    .value_o (lfsr_val)
  );

  assign rnd         = lfsr_val[GAP_BITS-1:0];
  // Upper LFSR bits only feed the feedback path, not the gap
  assign unused_lfsr = ^lfsr_val;
`else
  logic unused_cfg;

  // Deterministic build: every gap is exactly MIN_GAP and there is no LFSR
  assign rnd        = '0;
  assign unused_cfg = ^{SEED, lfsr_step};
`endif

  // Gap for the level that starts now; each level is held exactly this many cycles
  assign gap_new = 32'(MIN_GAP) + 32'(rnd);

  // Next-state and datapath update for the accept / bounce / settle sequence
  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gap_d     = gap_q;
    tog_d     = tog_q;
    set_d     = set_q;
    lfsr_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          // Target level appears immediately, even if it equals the current level
          sw_d   = level_i;
          busy_d = 1'b1;
          if (BOUNCES > 0) begin
            state_d   = BOUNCE;
            gap_d     = gap_new;
            tog_d     = '0;
            lfsr_step = 1'b1;
          end else begin
            state_d = bounce_gen_pkg::SETTLE;
            set_d   = SETTLE_LOAD;
          end
        end
      end

      BOUNCE: begin
        if (gap_q == 32'd1) begin
          sw_d = ~sw_q;
          if (tog_q == LAST_TOG) begin
            // Even toggle count: sw_o is back on target, start the clean hold
            state_d = bounce_gen_pkg::SETTLE;
            set_d   = SETTLE_LOAD;
          end else begin
            tog_d     = tog_q + 1'b1;
            gap_d     = gap_new;
            lfsr_step = 1'b1;
          end
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end

      bounce_gen_pkg::SETTLE: begin
        if (set_q == SETTLE_LAST) begin
          // busy drops on the same edge that raises done, so a new request lands in the done cycle
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          set_d = set_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transition without a done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      tog_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      tog_q   <= tog_d;
      set_q   <= set_d;
    end
  end

  assign sw_o        = sw_q;
  assign busy_o      = busy_q;
  assign done_tick_o = done_q;

endmodule

// File: doc/bounce_gen.md
# bounce_gen

- Synthesizable mechanical-switch emulator: the transmit side of the switch/debouncer path.
- On a request it drives `sw_o` to a target level through a burst of glitch toggles, then holds the level clean for a settle interval and reports completion.
- Sits in front of the debouncer in FPGA self-test builds and in the directed bench, replacing manual switch stimulus.

## Interface

Parameters:
- `BOUNCES`, 4 — glitch pairs per transition; 0 gives a clean edge.
- `MIN_GAP`, 10 — minimum cycles `sw_o` holds each bounce level; must be ≥1.
- `GAP_BITS`, 6 — width of the random gap extension; extra gap is 0 to 2^GAP_BITS−1.
- `SETTLE`, 1000 — cycles the final level is held before completion; must be ≥1.
- `SEED`, 16'hACE1 — LFSR reset value; 0 is illegal and is replaced by 16'h0001.

Ports:
- `clk_i` in 1 — clock.
- `rst_i` in 1 — reset; one clock, synchronous, active-high.
- `req_i` in 1 — request a transition; sampled only while idle.
- `level_i` in 1 — target level, captured with an accepted `req_i`.
- `sw_o` out 1 — emulated bouncy switch output, registered.
- `busy_o` out 1 — high while a transition is in progress.
- `done_tick_o` out 1 — single-cycle pulse when the settle interval completes.

## Operation

- FSM states:
  - `IDLE` → `BOUNCE` on accept when `BOUNCES>0`.
  - `IDLE` → `SETTLE` on accept when `BOUNCES==0`.
  - `BOUNCE` → `SETTLE` after the last toggle's gap expires.
  - `SETTLE` → `IDLE` after `SETTLE` cycles.
- Accept: `req_i && state==IDLE`. On the accepting edge the block captures `level_i`, sets `sw_o <= level_i`, loads the gap counter and raises `busy_o`.
- `BOUNCE`:
  - `sw_o` toggles 2·`BOUNCES` times. Each level is held exactly `gap` cycles.
  - Because the toggle count is even, `sw_o` ends on the target level.
  - `gap = MIN_GAP + lfsr[GAP_BITS-1:0]`, computed as an unsigned 32-bit add.
  - A new gap is loaded at every toggle, including the first one at accept.
- LFSR:
  - 16-bit Galois, polynomial 16'hB400.
  - Advances exactly once per gap load and holds otherwise.
  - Not reset between requests, so sequences continue across transitions.
- `SETTLE`: `sw_o` is constant at target for exactly `SETTLE` cycles. Then `done_tick_o` pulses and the FSM returns to `IDLE`.
- Target equal to the current `sw_o` is still a full transition. The first "toggle" is a no-change; the bounce schedule is unchanged.
- Reset values:
  - `sw_o=0`, `busy_o=0`, `done_tick_o=0`.
  - `lfsr=SEED`, counters 0, state `IDLE`.
- Reset mid-operation aborts immediately. No `done_tick_o` is issued, and `sw_o` returns to 0 on the reset edge.

## Timing

- Let E0 be the accepting edge.
  - `sw_o` takes `level_i` from E0.
  - Toggles occur at E0+g0, E0+g0+g1, … where gi are the loaded gaps.
- `done_tick_o` is high for the cycle starting at edge E0 + Σgi + `SETTLE`.
  - With fixed gaps: E0 + 2·`BOUNCES`·`MIN_GAP` + `SETTLE`.
  - For `BOUNCES==0`: E0 + `SETTLE`.
- `busy_o` rises at E0 and falls on the same edge that raises `done_tick_o`.
- `req_i` is accepted in the `done_tick_o` cycle, giving back-to-back transitions with no idle gap.
- `req_i` while busy is ignored and not queued.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- `BOUNCE_GEN_RANDOM_EN` defined:
  - The LFSR is instantiated.
  - Gaps are `MIN_GAP + lfsr[GAP_BITS-1:0]`.
- Not defined:
  - No LFSR logic is present.
  - Every gap equals `MIN_GAP` exactly.
  - `SEED` and `GAP_BITS` are unused.
  - Timing becomes fully deterministic, giving the fixed-gap formula above.

## Structure

- `bounce_gen_pkg` holds:
  - the `state_t` enum (`IDLE`, `BOUNCE`, `SETTLE`);
  - `LFSR_POLY = 16'hB400`;
  - `LFSR_DEFAULT_SEED`;
  - function `lfsr_next(logic [15:0])`.
- Sub-module `bounce_lfsr` has ports `clk_i`, `rst_i`, `step_i`, `value_o`.
  - Seed sanitization lives inside it.
  - It is instantiated only under `BOUNCE_GEN_RANDOM_EN`.
- The top level holds the FSM, gap counter, toggle counter (`$clog2(2*BOUNCES+1)` bits) and settle counter.

## Test plan

1. **Fixed gaps.** Macro off, `BOUNCES=2`, `MIN_GAP=10`, `SETTLE=100`. `req_i=1`, `level_i=1` at E0.
   - `sw_o` toggles at E0, +10, +20, +30, +40, ending at 1.
   - `done_tick_o` one cycle at E0+140; `busy_o` low from E0+140.
2. **Clean edge.** `BOUNCES=0`, `SETTLE=50`, `level_i=1`.
   - Exactly one `sw_o` edge at E0; `done_tick_o` at E0+50.
3. **Request while busy.** Pulse `req_i`, `level_i=0` at E0+15 during test 1.
   - Ignored: `sw_o` schedule and `done_tick_o` timing unchanged.
   - Second request issued in the `done_tick_o` cycle is accepted on that edge.
4. **Reset mid-bounce.** Assert `rst_i` at E0+25 in test 1.
   - Next cycle: `sw_o=0`, `busy_o=0`, no `done_tick_o`; a new request then behaves as in test 1.
5. **Random gaps.** Macro on, `BOUNCES=4`, `MIN_GAP=10`, `GAP_BITS=4`.
   - Every held interval is in 10..25 cycles.
   - The gap sequence matches a bench `lfsr_next` model from `SEED`.
   - Bench debouncer emits exactly one `db_tick_o`.
